// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage: writeback-select codes,
// FSM state type, the latched EX/MEM payload and the writeback mux.
package mem_pkg;

    localparam logic [1:0] WD_C   = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;
    localparam logic [1:0] WD_EXT = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic        wen;
        logic        rfwr;
        logic [1:0]  wdsel;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] c;
        logic [31:0] rd2;
        logic [31:0] wr;
        logic [31:0] ext;
    } payload_t;

    function automatic logic [31:0] wd_mux(
        input logic [1:0]  sel,
        input logic [31:0] c,
        input logic [31:0] mem,
        input logic [31:0] pc4,
        input logic [31:0] ext
    );
        case (sel)
            WD_C:    wd_mux = c;
            WD_MEM:  wd_mux = mem;
            WD_PC4:  wd_mux = pc4;
            default: wd_mux = ext;
        endcase
    endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads on retire, otherwise drops the valid and
// write-enable bits while the payload fields hold.
module mem_wb_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        retire,
    input  logic        rfwr_d,
    input  logic [31:0] wr_d,
    input  logic [31:0] wd_d,
    input  logic [31:0] pc_d,
    output logic        running,
    output logic        RFWr,
    output logic [31:0] wR,
    output logic [31:0] wD,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            RFWr    <= 1'b0;
            wR      <= '0;
            wD      <= '0;
            pc      <= '0;
        end else if (retire) begin
            running <= 1'b1;
            RFWr    <= rfwr_d;
            wR      <= wr_d;
            wD      <= wd_d;
            pc      <= pc_d;
        end else begin
            running <= 1'b0;
            RFWr    <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: issues data-memory accesses, waits for dm_ready with a bounded
// timeout, flags misaligned/timed-out accesses and feeds the MEM/WB register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        running_in,
    input  logic        WEn_in,
    input  logic        RFWr_in,
    input  logic [1:0]  WDSel_in,
    input  logic [31:0] pc_in,
    input  logic [31:0] pc4_in,
    input  logic [31:0] C_in,
    input  logic [31:0] rD2_in,
    input  logic [31:0] wR_in,
    input  logic [31:0] ext_in,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic [31:0] dm_rdata,
    output logic        stall,
    output logic        running,
    output logic        RFWr,
    output logic [31:0] wR,
    output logic [31:0] wD,
    output logic [31:0] pc,
    output logic        err
);

    localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

    state_t     state_reg;
    logic [7:0] cnt_reg;
    payload_t   lat_reg;
    logic       err_reg;

    payload_t    in_p;
    payload_t    cur;
    logic        in_wait;
    logic        is_mem;
    logic        misaligned;
    logic        issue;
    logic        timeout;
    logic        retire;
    logic        ret_rfwr;
    logic [31:0] wd_next;

    assign in_p = '{wen: WEn_in, rfwr: RFWr_in, wdsel: WDSel_in, pc: pc_in,
                    pc4: pc4_in, c: C_in, rd2: rD2_in, wr: wR_in, ext: ext_in};

    always_comb begin
        in_wait    = (state_reg == WAIT);
        is_mem     = running_in && (WEn_in || WDSel_in == WD_MEM);
        misaligned = !in_wait && is_mem && (C_in[1:0] != 2'b00);
        issue      = !in_wait && is_mem && (C_in[1:0] == 2'b00);
        timeout    = in_wait && !dm_ready && (cnt_reg == LAST_CNT);
        // In WAIT the bus is driven only from the latched copy.
        cur        = in_wait ? lat_reg : in_p;
        dm_req     = issue || in_wait;
        dm_we      = cur.wen;
        dm_addr    = cur.c;
        dm_wdata   = cur.rd2;
        // Stall drops in the cycle the access retires so upstream may advance.
        stall      = dm_req && !dm_ready && !timeout;
        retire     = in_wait ? (dm_ready || timeout)
                             : (running_in && (!issue || dm_ready));
        ret_rfwr   = cur.rfwr && !timeout && !misaligned;
        wd_next    = wd_mux(cur.wdsel, cur.c, dm_rdata, cur.pc4, cur.ext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            lat_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (issue) begin
                        lat_reg <= in_p;
                        if (!dm_ready) begin
                            state_reg <= WAIT;
                            cnt_reg   <= '0;
                        end
                    end
                    if (misaligned) err_reg <= 1'b1;
                end
                WAIT: begin
                    if (dm_ready) begin
                        state_reg <= IDLE;
                    end else if (timeout) begin
                        state_reg <= IDLE;
                        err_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign err = err_reg;

    mem_wb_reg u_mem_wb_reg (
        .clk     (clk),
        .rst     (rst),
        .retire  (retire),
        .rfwr_d  (ret_rfwr),
        .wr_d    (cur.wr),
        .wd_d    (wd_next),
        .pc_d    (cur.pc),
        .running (running),
        .RFWr    (RFWr),
        .wR      (wR),
        .wD      (wD),
        .pc      (pc)
    );

endmodule
